// File: rtl/fpu_mul_seq_if.sv
// Operand/result handshake bundle for the sequential binary32 multiplier.
// The master drives operands and consumes the result; the slave is the multiplier.
interface fpu_mul_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] o;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, o, out_valid
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, o, out_valid
  );
endinterface

// File: rtl/fpu_mul_seq.sv
// Sequential IEEE-754 binary32 multiplier: radix-2 shift-add over 24 cycles,
// then one normalize/round cycle, result held on a valid/ready port.
module fpu_mul_seq (
  input  logic          clk,
  input  logic          rst_n,
  fpu_mul_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t             state;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [31:0]        o_r;
  logic [47:0]        acc_r;
  logic [4:0]         cnt_r;

  logic               sign_r;
  logic [47:0]        mcand_r;
  logic [23:0]        mplier_r;
  logic signed [9:0]  exp_r;
  logic               nan_r, inf_r, zero_r;

  logic [7:0]         ea, eb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               nan_in, inf_in, zero_in;
  logic               accept;
  logic [31:0]        norm_res;

  // Normalize the 48-bit product, round to nearest-even, then clamp the range.
  function automatic logic [31:0] round_pack(input logic sgn, input logic [47:0] p,
                                             input logic signed [9:0] e);
    logic [22:0]       mant;
    logic              g, s, up;
    logic signed [9:0] ex;
    logic [23:0]       m_r;
    logic [31:0]       res;
    if (p[47]) begin
      mant = p[46:24];
      g    = p[23];
      s    = |p[22:0];
      ex   = e + 10'sd1;
    end else begin
      mant = p[45:23];
      g    = p[22];
      s    = |p[21:0];
      ex   = e;
    end
    up  = g & (s | mant[0]);
    m_r = {1'b0, mant} + 24'(up);
    if (m_r[23]) ex = ex + 10'sd1;
    if (ex >= 10'sd255)
      res = {sgn, 8'hFF, 23'h0};
    else if (ex <= 10'sd0)
      res = {sgn, 31'h0};
    else
      res = {sgn, ex[7:0], m_r[22:0]};
    return res;
  endfunction

  assign ea     = bus.a[30:23];
  assign eb     = bus.b[30:23];
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (bus.a[22:0] == 23'h0);
  assign b_inf  = (eb == 8'hFF) && (bus.b[22:0] == 23'h0);
  assign a_nan  = (ea == 8'hFF) && (bus.a[22:0] != 23'h0);
  assign b_nan  = (eb == 8'hFF) && (bus.b[22:0] != 23'h0);

  assign nan_in  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
  assign inf_in  = (a_inf | b_inf) & ~nan_in;
  assign zero_in = (a_zero | b_zero) & ~nan_in;

  assign accept = bus.in_valid && in_ready_r;

  always_comb begin
    norm_res = round_pack(sign_r, acc_r, exp_r);
    if (nan_r)
      norm_res = 32'h7FC0_0000;
    else if (inf_r)
      norm_res = {sign_r, 8'hFF, 23'h0};
    else if (zero_r)
      norm_res = {sign_r, 31'h0};
  end

  // Control, accumulator and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      o_r         <= 32'h0;
      acc_r       <= 48'h0;
      cnt_r       <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_r      <= 48'h0;
            cnt_r      <= 5'd0;
            in_ready_r <= 1'b0;
            state      <= MUL;
          end
        end
        MUL: begin
          if (mplier_r[0]) acc_r <= acc_r + mcand_r;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd23) state <= NORM;
        end
        NORM: begin
          o_r         <= norm_res;
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand datapath; only meaningful between accept and NORM
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      sign_r   <= bus.a[31] ^ bus.b[31];
      mcand_r  <= {24'h0, 1'b1, bus.a[22:0]};
      mplier_r <= {1'b1, bus.b[22:0]};
      exp_r    <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
      nan_r    <= nan_in;
      inf_r    <= inf_in;
      zero_r   <= zero_in;
    end else if (state == MUL) begin
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.o         = o_r;

endmodule

// File: tb/tb_fpu_mul_seq.sv
// Directed bench for fpu_mul_seq: arithmetic, rounding, range, specials,
// backpressure and mid-operation reset.
module tb_fpu_mul_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fpu_mul_seq_if bus();

  fpu_mul_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
  endtask

  task automatic wait_result(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd25);
    chk(tag, bus.o, exp);
  endtask

  task automatic release_out(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_vld_fall"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp);
    start_op(av, bv);
    wait_result(tag, exp);
    release_out(tag);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    bus.in_valid  = 1'b0;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #12;
    chk("rst_o",        bus.o,                 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid),   32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),    32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_2x3",     32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    run_op("mul_neg",     32'h3FC0_0000, 32'hC020_0000, 32'hC070_0000);
    run_op("round_tie",   32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002);
    run_op("overflow",    32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000);
    run_op("underflow",   32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
    run_op("inf_x_zero",  32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
    run_op("nzero_x_one", 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000);
    run_op("ninf_x_two",  32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
    run_op("nan_x_one",   32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000);

    // Backpressure: hold the result, try to push new operands meanwhile
    start_op(32'h4000_0000, 32'h4040_0000);
    wait_result("bp", 32'h40C0_0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = (i == 1 || i == 2);
      bus.a        = 32'h3F80_0000;
      bus.b        = 32'h3F80_0000;
      @(posedge clk);
      #1;
      chk("bp_o_hold",    bus.o,                32'h40C0_0000);
      chk("bp_in_ready",  32'(bus.in_ready),    32'd0);
      chk("bp_out_valid", 32'(bus.out_valid),   32'd1);
    end
    bus.in_valid = 1'b0;
    release_out("bp");
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_new_op", 32'(bus.out_valid), 32'd0);
    chk("bp_idle",      32'(bus.in_ready),  32'd1);

    // Reset during MUL at E10
    start_op(32'h3FC0_0000, 32'hC020_0000);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_o",         bus.o,              32'h0);
    chk("mrst_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_no_partial", 32'(bus.out_valid), 32'd0);
    run_op("after_rst", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
